// File: rtl/pipe_addsub.sv
// Segmented pipelined adder/subtractor: one SEG-bit slice resolved per stage with
// a registered ripple carry, and a valid/ready handshake on every stage.
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             sub;
    } beat_t;

    beat_t [STAGES-1:0] pipe;
    beat_t [STAGES-1:0] nxt;
    beat_t [STAGES:0]   chain;
    beat_t              beat_in;
    logic  [STAGES-1:0] vld_pipe;
    logic  [STAGES:0]   vld_chain;
    logic  [STAGES-1:0] rdy;

    always_comb begin
        beat_in.a   = a;
        beat_in.bx  = sub ? ~b : b;
        beat_in.sum = '0;
        beat_in.c   = sub ? ~cin : cin;
        beat_in.sub = sub;
    end

    // chain[k] / vld_chain[k] are the inputs seen by stage k
    assign chain     = {pipe, beat_in};
    assign vld_chain = {vld_pipe, in_valid};

    always_comb begin : resolve
        beat_t        src;
        logic [SEG:0] part;
        nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            src  = chain[k];
            part = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.bx[k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src.c};
            nxt[k] = src;
            nxt[k].sum[k*SEG +: SEG] = part[SEG-1:0];
            nxt[k].c = part[SEG];
        end
    end

    // A stage can load unless it and every stage after it are full and the sink stalls.
    always_comb begin : ready_chain
        logic full;
        full = 1'b1;
        rdy  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full   = full & vld_pipe[k];
            rdy[k] = !full || out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            pipe     <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_pipe[k] <= vld_chain[k];
                    if (vld_chain[k])
                        pipe[k] <= nxt[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = pipe[STAGES-1].sum;
    assign cout      = pipe[STAGES-1].sub ^ pipe[STAGES-1].c;
    assign ovf       = (pipe[STAGES-1].a[WIDTH-1] == pipe[STAGES-1].bx[WIDTH-1])
                    && (pipe[STAGES-1].sum[WIDTH-1] != pipe[STAGES-1].a[WIDTH-1]);

endmodule
